filtro_dac_tx: RTL and testbench
================================

// Module: filtro_dac_tx
// PURPOSE
//  Output end of the recursive-filter datapath: reads a filter output sample and serialises it to an SPI DAC.
//  The sample is scaled, saturated and converted to offset binary. The frame is 16 bits: 4 control bits and 12 data bits.
//  Sits after the filter output register; the sample-rate strobe (44 kHz) drives start.
// PARAMETERS
//  Width   25      width of signed two's-complement input sample
//  DacBits 12      DAC code width
//  ShiftR  10      arithmetic right shift applied before saturation
//  ClkDiv  4       clk cycles per sclk half-period (>=1)
//  Ctrl    4'b0000 control nibble sent ahead of data (DAC mode bits)
// PORTS
//  clk      in  1         system clock; all logic on rising edge
//  reset    in  1         synchronous, active-high reset
//  start    in  1         one-cycle request; datoIn is sampled on the same cycle
//  datoIn   in  Width     signed filter output sample
//  sync_n   out 1         DAC frame select, active low
//  sclk     out 1         serial clock, idles high
//  sdata    out 1         serial data, MSB first
//  busy     out 1         high while a frame is in progress (SHIFT or DONE)
//  done     out 1         one-cycle pulse at end of frame
//  overrun  out 1         sticky; set when start arrives while busy
// BEHAVIOUR
//  - All outputs are registered. Reset values: sync_n=1, sclk=1, sdata=0, busy=0, done=0, overrun=0; FSM=IDLE.
//  - Reset asserted mid-frame aborts the frame at the next edge with the reset values; no done pulse is issued.
//  - Scaling: s = datoIn >>> ShiftR (sign-preserving).
//    - If s > 2^(DacBits-1)-1, sat = max; if s < -2^(DacBits-1), sat = min; otherwise sat = s.
//    - code = {~sat[DacBits-1], sat[DacBits-2:0]} (offset binary). frame = {Ctrl, code}, 16 bits.
//  - FSM states: IDLE -> SHIFT -> DONE -> IDLE.
//  - IDLE: busy=0. If start=1 at edge k, the block latches frame and a bit counter=15 and goes to SHIFT.
//  - SHIFT, from cycle k+1:
//    - sync_n=0. Each bit lasts 2*ClkDiv cycles: sclk=1 for ClkDiv cycles, then sclk=0 for ClkDiv cycles.
//    - sdata changes only at the start of a bit (sclk rising) and holds frame[bit]; the DAC samples on the sclk falling edge.
//    - After the low phase of bit 0 the FSM goes to DONE. Duration of SHIFT is 32*ClkDiv cycles.
//  - DONE: one cycle with sync_n=1, sclk=1, done=1, busy=1; then IDLE (sdata holds its last value).
//  - Timing with start at edge k and ClkDiv=4:
//    - sync_n low during cycles k+1..k+128; done=1 at cycle k+129.
//    - A new start is accepted from cycle k+130.
//  - start while busy (SHIFT or DONE): ignored, the frame in flight is unaffected, and overrun<=1 until reset.
//  - start coinciding with reset: reset wins.
//  - The input is latched at start, so later changes to datoIn do not affect the frame.
// TESTING
//  1 reset, then start with datoIn=0 -> frame 16'h0800. Bench checks:
//    - sync_n low exactly 128 clk cycles; 16 sclk falling edges.
//    - done pulse at k+129.
//  2 datoIn=5120 -> code 12'h805; datoIn=-1024 -> code 12'h7FF; datoIn=-1 -> code 12'h7FF. Bits decoded on sclk falling edges.
//  3 datoIn=25'h0FFFFFF -> 12'hFFF (positive saturation); datoIn=25'h1000000 -> 12'h000 (negative saturation).
//  4 second start at k+50 -> ignored, overrun=1, first frame bits intact.
//    - Then start at k+130 -> new frame sent, overrun stays 1.
//  5 reset at k+40 during SHIFT -> next edge: sync_n=1, sclk=1, busy=0; no done pulse.
//    - A following start sends a full, correct frame.
//  6 ClkDiv=1, Ctrl=4'b0011, datoIn=0 -> frame 16'h3800; sync_n low 32 cycles; done at k+33.

Source files
------------

// File: rtl/filtro_dac_tx.sv
// Purpose : scales, saturates and offset-binary encodes one filter output sample, then shifts
//           a 16-bit {ctrl, code} frame MSB-first to an SPI DAC (sync_n / sclk / sdata).
// Latency : sync_n falls one cycle after start; frame lasts 32*ClkDiv cycles; done one cycle later.
// Backpressure: none; a start seen while busy is dropped and latches the sticky overrun flag.
//
// Ports:
//   clk      system clock, all logic on the rising edge
//   reset    synchronous active-high reset
//   start    one-cycle frame request; datoIn is sampled on the same edge
//   datoIn   signed two's-complement filter sample
//   sync_n   DAC frame select, active low
//   sclk     serial clock, idles high; DAC samples sdata on its falling edge
//   sdata    serial data, MSB first, changes only when sclk rises
//   busy     high during SHIFT and DONE
//   done     one-cycle pulse after the last bit
//   overrun  sticky: a start arrived while busy
module filtro_dac_tx #(
    parameter int          Width   = 25,
    parameter int          DacBits = 12,
    parameter int          ShiftR  = 10,
    parameter int          ClkDiv  = 4,
    parameter logic [3:0]  Ctrl    = 4'b0000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic signed [Width-1:0]  datoIn,
    output logic                     sync_n,
    output logic                     sclk,
    output logic                     sdata,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun
);

    localparam int FrameBits = 4 + DacBits;
    localparam int BitW      = $clog2(FrameBits);
    localparam int DivW      = $clog2(2 * ClkDiv);

    // Phase counter runs 0 .. 2*ClkDiv-1 within one bit: high phase first, low phase second.
    localparam logic [DivW-1:0] DivHalf = DivW'(ClkDiv - 1);
    localparam logic [DivW-1:0] DivLast = DivW'(2 * ClkDiv - 1);
    localparam logic [BitW-1:0] BitTop  = BitW'(FrameBits - 1);

    localparam logic signed [Width-1:0] SatMax = Width'((2 ** (DacBits - 1)) - 1);
    localparam logic signed [Width-1:0] SatMin = Width'(-(2 ** (DacBits - 1)));

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Sample conditioning: shift, clamp to DAC range, flip MSB for offset binary
    // ------------------------------------------------------------------
    logic signed [Width-1:0]   shifted;
    logic signed [DacBits-1:0] sat;
    logic [DacBits-1:0]        code;
    logic [FrameBits-1:0]      frame_in;

    always_comb begin
        shifted = datoIn >>> ShiftR;
        if (shifted > SatMax) begin
            sat = SatMax[DacBits-1:0];
        end else if (shifted < SatMin) begin
            sat = SatMin[DacBits-1:0];
        end else begin
            sat = shifted[DacBits-1:0];
        end
        code     = {~sat[DacBits-1], sat[DacBits-2:0]};
        frame_in = {Ctrl, code};
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_t                state_q,   state_d;
    logic [FrameBits-1:0]  frame_q,   frame_d;
    logic [BitW-1:0]       bit_q,     bit_d;
    logic [DivW-1:0]       div_q,     div_d;
    logic                  sync_n_q,  sync_n_d;
    logic                  sclk_q,    sclk_d;
    logic                  sdata_q,   sdata_d;
    logic                  busy_q,    busy_d;
    logic                  done_q,    done_d;
    logic                  overrun_q, overrun_d;

    logic [BitW-1:0]       bit_dn;

    assign bit_dn = bit_q - BitW'(1);

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        bit_d     = bit_q;
        div_d     = div_q;
        sync_n_d  = sync_n_q;
        sclk_d    = sclk_q;
        sdata_d   = sdata_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d  = ST_SHIFT;
                    frame_d  = frame_in;
                    bit_d    = BitTop;
                    div_d    = '0;
                    sync_n_d = 1'b0;
                    sclk_d   = 1'b1;
                    // First bit must be on the wire in the same cycle sync_n falls.
                    sdata_d  = frame_in[FrameBits-1];
                    busy_d   = 1'b1;
                end
            end

            ST_SHIFT: begin
                if (start) begin
                    overrun_d = 1'b1;
                end
                if (div_q == DivLast) begin
                    if (bit_q == '0) begin
                        state_d  = ST_DONE;
                        sync_n_d = 1'b1;
                        sclk_d   = 1'b1;
                        done_d   = 1'b1;
                    end else begin
                        // Next bit begins with sclk rising; sdata moves only here.
                        bit_d   = bit_dn;
                        div_d   = '0;
                        sclk_d  = 1'b1;
                        sdata_d = frame_q[bit_dn];
                    end
                end else begin
                    div_d = div_q + DivW'(1);
                    if (div_q == DivHalf) begin
                        sclk_d = 1'b0;
                    end
                end
            end

            ST_DONE: begin
                if (start) begin
                    overrun_d = 1'b1;
                end
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d  = ST_IDLE;
                sync_n_d = 1'b1;
                sclk_d   = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            frame_q   <= '0;
            bit_q     <= '0;
            div_q     <= '0;
            sync_n_q  <= 1'b1;
            sclk_q    <= 1'b1;
            sdata_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            bit_q     <= bit_d;
            div_q     <= div_d;
            sync_n_q  <= sync_n_d;
            sclk_q    <= sclk_d;
            sdata_q   <= sdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign sync_n  = sync_n_q;
    assign sclk    = sclk_q;
    assign sdata   = sdata_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_filtro_dac_tx.sv
// Purpose : scoreboard bench for filtro_dac_tx; two instances (default ClkDiv=4 / Ctrl=0, and
//           ClkDiv=1 / Ctrl=4'b0011). Expected frames queued at start, compared when sync_n rises.
// Latency : outputs sampled on the falling clock edge; inputs driven 1 time unit after rising edge.
module tb_filtro_dac_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a, start_b;
    logic [24:0] dato;
    logic        sync_n_a, sclk_a, sdata_a, busy_a, done_a, overrun_a;
    logic        sync_n_b, sclk_b, sdata_b, busy_b, done_b, overrun_b;

    always #5 clk = ~clk;

    filtro_dac_tx dut_a (
        .clk(clk), .reset(reset), .start(start_a), .datoIn(dato),
        .sync_n(sync_n_a), .sclk(sclk_a), .sdata(sdata_a),
        .busy(busy_a), .done(done_a), .overrun(overrun_a)
    );

    filtro_dac_tx #(.ClkDiv(1), .Ctrl(4'b0011)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .datoIn(dato),
        .sync_n(sync_n_b), .sclk(sclk_b), .sdata(sdata_b),
        .busy(busy_b), .done(done_b), .overrun(overrun_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: arithmetic shift, clamp, offset binary by adding half scale.
    function automatic logic [15:0] exp_frame(input logic [24:0] din, input logic [3:0] ctl);
        int v;
        int s;
        v = int'($signed(din));
        s = v >>> 10;
        if (s > 2047)  s = 2047;
        if (s < -2048) s = -2048;
        s = s + 2048;
        return {ctl, 12'(s)};
    endfunction

    logic [15:0] exp_a[$];
    logic [15:0] exp_b[$];
    int          kc_a[$];
    int          kc_b[$];

    function automatic int qsize(input int d);
        return (d == 0) ? exp_a.size() : exp_b.size();
    endfunction

    // Monitor state, indexed by instance
    int          low_cnt[2];
    int          falls[2];
    logic [15:0] bits[2];
    logic        prev_sync[2];
    logic        prev_sclk[2];
    logic        prev_done[2];
    bit          abort[2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            low_cnt[i] = 0; falls[i] = 0; bits[i] = '0;
            prev_sync[i] = 1'b1; prev_sclk[i] = 1'b1; prev_done[i] = 1'b0; abort[i] = 1'b0;
        end
    end

    task automatic mon_step(input int d, input logic s_n, input logic sc, input logic sd, input logic dn);
        logic [15:0] ef;
        int          kc;
        bit          have;
        int          per;
        per = (d == 0) ? 4 : 1;
        if (prev_done[d]) chk($sformatf("done_width%0d", d), 32'(dn), 32'd0);
        if (!s_n) begin
            low_cnt[d]++;
            if (prev_sclk[d] && !sc) begin
                bits[d] = {bits[d][14:0], sd};
                falls[d]++;
            end
        end else if (!prev_sync[d]) begin
            have = 1'b0;
            ef   = '0;
            kc   = 0;
            if (d == 0 && exp_a.size() > 0) begin
                have = 1'b1; ef = exp_a.pop_front(); kc = kc_a.pop_front();
            end else if (d == 1 && exp_b.size() > 0) begin
                have = 1'b1; ef = exp_b.pop_front(); kc = kc_b.pop_front();
            end
            if (!have) begin
                chk($sformatf("unexpected_frame%0d", d), 32'd1, 32'd0);
            end else if (abort[d]) begin
                chk($sformatf("abort_no_done%0d", d), 32'(dn), 32'd0);
                abort[d] = 1'b0;
            end else begin
                chk($sformatf("frame%0d", d), 32'(bits[d]), 32'(ef));
                chk($sformatf("sync_low_cycles%0d", d), 32'(low_cnt[d]), 32'(32 * per));
                chk($sformatf("sclk_falls%0d", d), 32'(falls[d]), 32'd16);
                chk($sformatf("done_pulse%0d", d), 32'(dn), 32'd1);
                chk($sformatf("done_latency%0d", d), 32'(cyc - kc), 32'(32 * per));
            end
            low_cnt[d] = 0;
            falls[d]   = 0;
            bits[d]    = '0;
        end
        prev_sync[d] = s_n;
        prev_sclk[d] = sc;
        prev_done[d] = dn;
    endtask

    always @(negedge clk) begin
        mon_step(0, sync_n_a, sclk_a, sdata_a, done_a);
        mon_step(1, sync_n_b, sclk_b, sdata_b, done_b);
    end

    // Called 1 time unit after a rising edge; returns 1 time unit after the sampling edge.
    task automatic send(input int d, input logic [24:0] din, input bit accept);
        dato = din;
        if (d == 0) start_a = 1'b1; else start_b = 1'b1;
        if (accept) begin
            if (d == 0) begin
                exp_a.push_back(exp_frame(din, 4'b0000)); kc_a.push_back(cyc + 1);
            end else begin
                exp_b.push_back(exp_frame(din, 4'b0011)); kc_b.push_back(cyc + 1);
            end
        end
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        dato    = 25'($urandom);
    endtask

    task automatic wait_drain(input int d);
        int n;
        n = 0;
        while (qsize(d) != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk($sformatf("drain%0d", d), 32'(qsize(d)), 32'd0);
    endtask

    logic [24:0] vec[8];

    initial begin
        vec[0] = 25'd0;
        vec[1] = 25'd5120;
        vec[2] = 25'h1FFFC00;   // -1024
        vec[3] = 25'h1FFFFFF;   // -1
        vec[4] = 25'h0FFFFFF;   // positive saturation
        vec[5] = 25'h1000000;   // negative saturation
        vec[6] = 25'h01FFC00;   // just below positive clamp after shift
        vec[7] = 25'($urandom);

        reset   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        dato    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sync_n",  32'(sync_n_a),  32'd1);
        chk("rst_sclk",    32'(sclk_a),    32'd1);
        chk("rst_sdata",   32'(sdata_a),   32'd0);
        chk("rst_busy",    32'(busy_a),    32'd0);
        chk("rst_done",    32'(done_a),    32'd0);
        chk("rst_overrun", 32'(overrun_a), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Frames through the default instance, including saturation cases
        for (int i = 0; i < 8; i++) begin
            send(0, vec[i], 1'b1);
            chk("busy_after_start", 32'(busy_a), 32'd1);
            chk("sync_low_after_start", 32'(sync_n_a), 32'd0);
            wait_drain(0);
        end
        chk("no_overrun_yet", 32'(overrun_a), 32'd0);

        // Start while busy is dropped; start right after DONE is accepted
        send(0, 25'd7168, 1'b1);             // edge k
        repeat (49) @(posedge clk);
        #1;
        send(0, 25'h0FFFFFF, 1'b0);          // edge k+50
        chk("overrun_set", 32'(overrun_a), 32'd1);
        repeat (79) @(posedge clk);
        #1;
        send(0, 25'h1FFEC00, 1'b1);          // edge k+130
        chk("accept_at_k130", 32'(busy_a), 32'd1);
        chk("overrun_sticky", 32'(overrun_a), 32'd1);
        wait_drain(0);

        // Reset mid-frame aborts without done
        send(0, 25'd3072, 1'b1);             // edge k
        repeat (39) @(posedge clk);
        #1;
        reset    = 1'b1;
        abort[0] = 1'b1;
        @(posedge clk);                      // edge k+40
        #1;
        chk("abort_sync_n",  32'(sync_n_a),  32'd1);
        chk("abort_sclk",    32'(sclk_a),    32'd1);
        chk("abort_busy",    32'(busy_a),    32'd0);
        chk("abort_done",    32'(done_a),    32'd0);
        chk("abort_overrun", 32'(overrun_a), 32'd0);
        reset = 1'b0;
        wait_drain(0);
        send(0, 25'd2048, 1'b1);
        wait_drain(0);

        // Start coinciding with reset: reset wins
        reset   = 1'b1;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        start_a = 1'b0;
        chk("rst_start_busy",   32'(busy_a),   32'd0);
        chk("rst_start_sync_n", 32'(sync_n_a), 32'd1);
        @(posedge clk);
        #1;
        chk("rst_start_idle", 32'(busy_a), 32'd0);

        // Fast divider and non-zero control nibble
        send(1, 25'd0, 1'b1);
        chk("b_busy", 32'(busy_b), 32'd1);
        wait_drain(1);
        send(1, 25'd5120, 1'b1);
        wait_drain(1);
        send(1, 25'h1000000, 1'b1);
        wait_drain(1);

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
